// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and opcode constants for the ALU command sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int unsigned OP_ADD       = 0;
    localparam int unsigned OP_SUB       = 1;
    localparam int unsigned OP_INC       = 2;
    localparam int unsigned OP_DEC       = 3;
    localparam int unsigned OP_MAX_LEGAL = 3;

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - synchronous command FIFO with occupancy count, power-of-two depth
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - queues ALU commands, issues them one at a time and returns the registered result.
// Optional build macro ALU_SEQ_ILLEGAL_CHK_EN: answer opcodes above OP_MAX_LEGAL with an error response.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int OPCODE_WIDTH = 2,
    parameter int DATA_WIDTH   = 1,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH:0]   cmd_opcode,
    input  logic [DATA_WIDTH:0]     cmd_op1,
    input  logic [DATA_WIDTH:0]     cmd_op2,
    output logic [OPCODE_WIDTH:0]   alu_opcode,
    output logic [DATA_WIDTH:0]     alu_op1,
    output logic [DATA_WIDTH:0]     alu_op2,
    input  logic [DATA_WIDTH:0]     alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH:0]     rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  cmd_count
);
    localparam int OW = OPCODE_WIDTH + 1;
    localparam int DW = DATA_WIDTH + 1;
    localparam int FW = OW + 2 * DW;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rdata;
    logic [OW-1:0] head_opcode;
    logic [DW-1:0] head_op1;
    logic [DW-1:0] head_op2;
    logic          head_illegal;
    logic          launch;

    state_e        state_q,      state_d;
    logic [OW-1:0] alu_opcode_q, alu_opcode_d;
    logic [DW-1:0] alu_op1_q,    alu_op1_d;
    logic [DW-1:0] alu_op2_q,    alu_op2_d;
    logic [DW-1:0] rsp_result_q, rsp_result_d;
    logic          rsp_carry_q,  rsp_carry_d;
    logic          rsp_zero_q,   rsp_zero_d;
    logic          rsp_err_q,    rsp_err_d;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign {head_opcode, head_op1, head_op2} = fifo_rdata;

    alu_seq_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata ({cmd_opcode, cmd_op1, cmd_op2}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cmd_count)
    );

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    localparam logic [OW-1:0] MAX_LEGAL = OW'(OP_MAX_LEGAL);
    assign head_illegal = (head_opcode > MAX_LEGAL);
`else
    assign head_illegal = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;
        launch       = 1'b0;

        case (state_q)
            IDLE:    launch = !fifo_empty;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                rsp_err_d    = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    launch  = !fifo_empty;
                end
            end
            default: state_d = IDLE;
        endcase

        // Illegal commands skip the ALU entirely, leaving alu_* on the last legal command.
        if (launch) begin
            fifo_pop = 1'b1;
            if (head_illegal) begin
                rsp_result_d = '0;
                rsp_carry_d  = 1'b0;
                rsp_zero_d   = 1'b0;
                rsp_err_d    = 1'b1;
                state_d      = RESP;
            end else begin
                alu_opcode_d = head_opcode;
                alu_op1_d    = head_op1;
                alu_op2_d    = head_op2;
                state_d      = ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer sitting directly upstream of the ALU datapath stage. Buffers operation commands from the control path in a small FIFO and issues them one at a time to the ALU's OPCODE/OP1/OP2 inputs. Accounts for the ALU's one-cycle registered latency, captures RESULT/CARRY/ZERO, and returns them over a valid/ready response channel.

## Interface
Parameters:
- OPCODE_WIDTH, 2, opcode port width is OPCODE_WIDTH+1 bits (matches ALU)
- DATA_WIDTH, 1, operand/result port width is DATA_WIDTH+1 bits (matches ALU)
- DEPTH, 4, command FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock for all logic
- rstn  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_opcode  in  OPCODE_WIDTH+1  operation
- cmd_op1  in  DATA_WIDTH+1  operand 1
- cmd_op2  in  DATA_WIDTH+1  operand 2
- alu_opcode  out  OPCODE_WIDTH+1  to ALU OPCODE, registered
- alu_op1  out  DATA_WIDTH+1  to ALU OP1, registered
- alu_op2  out  DATA_WIDTH+1  to ALU OP2, registered
- alu_result  in  DATA_WIDTH+1  from ALU RESULT
- alu_carry  in  1  from ALU CARRY
- alu_zero  in  1  from ALU ZERO
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  DATA_WIDTH+1  captured result
- rsp_carry  out  1  captured carry
- rsp_zero  out  1  captured zero
- rsp_err  out  1  illegal-opcode response (see Configuration)
- cmd_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push on cmd_valid && cmd_ready. No bypass: a pop in the same cycle does not raise cmd_ready when full.
- FIFO pointers wrap modulo DEPTH. Occupancy counter 0..DEPTH. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty → pop head, load alu_* regs, go to ISSUE. Otherwise stay.
  - ISSUE: alu_* stable; the ALU samples them at this edge. Go to CAPTURE.
  - CAPTURE: ALU outputs valid; latch them into rsp_* with rsp_err=0. Go to RESP.
  - RESP: rsp_valid=1, rsp_* held stable. On rsp_ready: if FIFO non-empty → pop and load alu_*, go to ISSUE; else go to IDLE. Without rsp_ready, stay (backpressure; FIFO keeps filling).
- alu_* regs hold the last issued command outside ISSUE.
- Widths: operands pass through unmodified. The sequencer does no arithmetic; flag semantics are the ALU's (carry = result bit DATA_WIDTH+1, zero = full-width result == 0).
- Reset: all outputs 0 (cmd_ready=1 from the empty FIFO, cmd_count=0), state IDLE, pointers 0. Asserting reset mid-operation flushes the FIFO and discards any in-flight ALU result. The ALU sharing rstn also clears.

## Timing
- Command accepted at edge E0 → IDLE pop at E1 → ISSUE cycle after E1 → CAPTURE after E2 → rsp_valid high after E3.
- Empty-queue latency is 3 edges after the accepting edge.
- Sustained throughput with rsp_ready held high: one response per 3 cycles.
- rsp_valid, once high, never drops without a handshake, except on reset.

## Configuration
- ALU_SEQ_ILLEGAL_CHK_EN defined: opcodes > 3 are not issued. IDLE/RESP popping such a command goes straight to RESP with rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=1. alu_* are not updated. Latency is 1 edge after the pop.
- Not defined: all opcodes are forwarded to the ALU unchanged, and rsp_err is tied 0.

## Structure
- Package alu_seq_pkg holds:
  - state enum (IDLE, ISSUE, CAPTURE, RESP)
  - opcode constants OP_ADD=0, OP_SUB=1, OP_INC=2, OP_DEC=3
  - OP_MAX_LEGAL=3
- Sub-module alu_seq_fifo: parameterised synchronous FIFO with push/pop/full/empty/count. The top level contains the FSM and response registers.

## Test plan
All cases use DATA_WIDTH=1 and the real ALU connected.
- ADD op1=3, op2=1 → rsp_result=0, rsp_carry=1, rsp_zero=0; rsp_valid exactly 3 edges after acceptance.
- Back-to-back SUB 1−2, INC 3, DEC 0 with rsp_ready=1 → results 3/1/0, 0/1/0, 3/1/0 (result/carry/zero), in order, at 3-cycle spacing.
- ADD 0+0 → rsp_zero=1, rsp_carry=0.
- Push 5 commands with rsp_ready=0 → after DEPTH pops/pushes cmd_ready=0 at count=4, and the first response stays stable. Releasing rsp_ready drains all commands in order; pointers wrap correctly.
- With ALU_SEQ_ILLEGAL_CHK_EN, opcode 5 between two ADDs → rsp_err=1, result 0; the ALU inputs keep the first ADD's values; ordering is preserved. Without the macro, rsp_err stays 0.
- Reset asserted in CAPTURE with 2 commands queued → next cycle rsp_valid=0, cmd_count=0, all outputs 0; no stale response appears after release.
